// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter: SHW binary shift levels spread across STAGES register
// stages, with carry/zero/illegal flags and valid/ready flow control on both sides.
module barrel_shifter_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [$clog2(WIDTH)-1:0]   in_amt,
  input  logic [2:0]                 in_mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_carry,
  output logic                       out_zero,
  output logic                       out_illegal
);

  localparam int SHW = $clog2(WIDTH);
  localparam int LPS = (SHW + STAGES - 1) / STAGES;

  localparam logic [2:0] MODE_SLL = 3'b000;
  localparam logic [2:0] MODE_SRL = 3'b001;
  localparam logic [2:0] MODE_SRA = 3'b010;
  localparam logic [2:0] MODE_ROL = 3'b011;
  localparam logic [2:0] MODE_ROR = 3'b100;

  logic             adv;
  logic             carry_in;
  logic [SHW-1:0]   left_idx;
  logic [SHW-1:0]   right_idx;

  logic [WIDTH-1:0] pipe_data  [STAGES];
  logic [SHW-1:0]   pipe_amt   [STAGES];
  logic [2:0]       pipe_mode  [STAGES];
  logic             pipe_carry [STAGES];
  logic             pipe_valid [STAGES];
  logic             zero_q;

  logic [WIDTH-1:0] src_data  [STAGES];
  logic [SHW-1:0]   src_amt   [STAGES];
  logic [2:0]       src_mode  [STAGES];
  logic             src_carry [STAGES];
  logic             src_valid [STAGES];
  logic [WIDTH-1:0] nxt_data  [STAGES];

  // Applies the shift levels lo..lo+LPS-1 owned by one stage; illegal modes pass through.
  function automatic logic [WIDTH-1:0] shift_levels(input logic [WIDTH-1:0] d,
                                                    input logic [SHW-1:0]   amt,
                                                    input logic [2:0]       mode,
                                                    input int               lo);
    logic [WIDTH-1:0] r;
    logic [SHW-1:0]   a;
    r = d;
    a = amt;
    for (int k = 0; k < SHW; k++) begin
      if (k >= lo && k < lo + LPS && a[0]) begin
        case (mode)
          MODE_SLL: r = r << (1 << k);
          MODE_SRL: r = r >> (1 << k);
          MODE_SRA: r = $unsigned($signed(r) >>> (1 << k));
          MODE_ROL: r = (r << (1 << k)) | (r >> (WIDTH - (1 << k)));
          MODE_ROR: r = (r >> (1 << k)) | (r << (WIDTH - (1 << k)));
          default:  r = r;
        endcase
      end
      a = a >> 1;
    end
    return r;
  endfunction

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Carry is taken from the original operand up front so later stages only forward one bit.
  // Negating the amount in SHW bits yields WIDTH-amt directly.
  always_comb begin
    left_idx  = SHW'(0) - in_amt;
    right_idx = in_amt - SHW'(1);
    carry_in  = 1'b0;
    if (in_amt != '0) begin
      case (in_mode)
        MODE_SLL, MODE_ROL:           carry_in = in_data[left_idx];
        MODE_SRL, MODE_SRA, MODE_ROR: carry_in = in_data[right_idx];
        default:                      carry_in = 1'b0;
      endcase
    end
  end

  always_comb begin
    src_data[0]  = in_data;
    src_amt[0]   = in_amt;
    src_mode[0]  = in_mode;
    src_carry[0] = carry_in;
    src_valid[0] = in_valid;
    for (int s = 1; s < STAGES; s++) begin
      src_data[s]  = pipe_data[s-1];
      src_amt[s]   = pipe_amt[s-1];
      src_mode[s]  = pipe_mode[s-1];
      src_carry[s] = pipe_carry[s-1];
      src_valid[s] = pipe_valid[s-1];
    end
    for (int s = 0; s < STAGES; s++) begin
      nxt_data[s] = shift_levels(src_data[s], src_amt[s], src_mode[s], s * LPS);
    end
  end

  // A single advance moves every stage at once, bubbles included, so a stall freezes the whole pipe.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < STAGES; s++) begin
        pipe_valid[s] <= 1'b0;
        pipe_data[s]  <= '0;
        pipe_amt[s]   <= '0;
        pipe_mode[s]  <= MODE_SLL;
        pipe_carry[s] <= 1'b0;
      end
      zero_q <= 1'b0;
    end else if (adv) begin
      for (int s = 0; s < STAGES; s++) begin
        pipe_valid[s] <= src_valid[s];
        pipe_data[s]  <= nxt_data[s];
        pipe_amt[s]   <= src_amt[s];
        pipe_mode[s]  <= src_mode[s];
        pipe_carry[s] <= src_carry[s];
      end
      zero_q <= (nxt_data[STAGES-1] == '0);
    end
  end

  assign out_valid   = pipe_valid[STAGES-1];
  assign out_data    = pipe_data[STAGES-1];
  assign out_carry   = pipe_carry[STAGES-1];
  assign out_zero    = zero_q;
  assign out_illegal = (pipe_mode[STAGES-1] > MODE_ROR);

endmodule

// File: doc/barrel_shifter_pipe.md
Name: barrel_shifter_pipe

Overview:
Parametrised, pipelined barrel shifter. It is the successor to the fixed 32-bit shift/rotate unit. It supports generic WIDTH, configurable pipeline depth, five shift modes, carry-out and zero flags, and valid/ready flow control on both sides. It sits between operand-issue logic and the result-writeback path of the datapath.

Parameters:
WIDTH, 32, data width; power of two, 4..64.
STAGES, 2, register stages from input to output, 1..log2(WIDTH); also the latency in cycles.
SHW, log2(WIDTH), derived; width of the shift amount; not overridable.

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  input operand valid
in_ready  output  1  block can accept an operand this cycle
in_data  input  WIDTH  operand
in_amt  input  SHW  shift amount, 0..WIDTH-1
in_mode  input  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101-111 illegal
out_valid  output  1  result valid
out_ready  input  1  downstream accepts the result
out_data  output  WIDTH  shifted result
out_carry  output  1  last bit shifted/rotated out
out_zero  output  1  out_data == 0
out_illegal  output  1  in_mode was 101-111

Behaviour:
- One clock, synchronous active-high reset. All state updates on the rising edge of clock.
- Shift network:
  - SHW binary levels; level k shifts by 2^k when in_amt[k]=1.
  - Levels are split across STAGES register boundaries. Stage s holds ceil(SHW/STAGES) levels; the last stage takes the remainder.
  - Each stage carries data, remaining amount bits, mode, original operand bits needed for carry, and a valid bit.
- Mode results:
  - SLL: zero fill.
  - SRL: zero fill.
  - SRA: fill with in_data[WIDTH-1].
  - ROL / ROR: circular rotate.
- Carry, for amt != 0:
  - Left modes (SLL, ROL): in_data[WIDTH-amt].
  - Right modes (SRL, SRA, ROR): in_data[amt-1].
  - amt == 0: carry = 0.
- Illegal mode: out_data = in_data unshifted, out_carry = 0, out_illegal = 1, out_zero computed normally.
- Flow control:
  - Global advance signal: adv = !out_valid || out_ready. in_ready = adv (combinational).
  - Transfer in occurs when in_valid && in_ready. Transfer out occurs when out_valid && out_ready.
  - When adv=1, every stage loads from its predecessor, bubbles included. When adv=0, all stage registers hold.
  - Latency: an accepted operand appears on out_valid exactly STAGES cycles later, provided no stall intervenes. Each stall cycle adds one cycle.
  - Throughput: one result per cycle when out_ready is held high.
  - Capacity: STAGES operands in flight. No operand is dropped or duplicated.
- Output stability: while out_valid=1 && out_ready=0, out_data, out_carry, out_zero and out_illegal hold constant.
- Reset:
  - All valid bits clear and out_data, out_carry, out_zero, out_illegal go to 0 on the edge where reset=1.
  - in_ready reads 1 from the cycle after reset.
  - Reset mid-operation discards all in-flight operands. An in_valid presented during reset is not accepted.
- in_amt >= WIDTH is impossible by width. in_amt = 0 returns in_data for all legal modes.

Test Plan:
- WIDTH=32, STAGES=2, out_ready=1. SLL 0x0000001F amt 1 at cycle t → out_valid at t+2, out_data 0x0000003E, carry 0, zero 0. Back-to-back SLL amt 1..5 on successive cycles → 0x3E, 0x7C, 0xF8, 0x1F0, 0x3E0 on consecutive cycles.
- ROL 0xF0000001 amt 4 → 0x0000001F, carry 1. ROR 0x00000003 amt 1 → 0x80000001, carry 1.
- SRA 0x80000000 amt 31 → 0xFFFFFFFF, carry 0. SRL same operand → 0x00000001, carry 0. SRL 0x0000000F amt 4 → 0x00000000, zero 1, carry 1.
- Backpressure: hold out_ready=0 and offer 4 operands. Exactly 2 accepted; in_ready low thereafter; out_data stable. Release out_ready → results delivered in order, then the remaining 2 accepted.
- Illegal mode 110, 0x12345678 amt 7 → out_data 0x12345678, illegal 1, carry 0.
- Reset asserted with 2 operands in flight → next cycle out_valid=0 and all outputs 0; no stale result appears afterward.
